inst_fetch_queue: RTL
=====================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction buffer between the IF1 stage and decode. Accepts one fetch packet per cycle
//  (aligned 64-bit pair: two instructions, packet PC, exception info) and compacts the valid
//  slots into a circular queue. Presents the two oldest entries to a dual-issue decoder,
//  which pops 0, 1 or 2 entries per cycle. A flush empties the queue in one cycle.
// PARAMETERS
//  DEPTH    8   entries; power of 2, >= 4
//  PTR_W    3   log2(DEPTH); count register is PTR_W+1 bits wide
// PORTS
//  clk            in   1   sole clock, rising edge
//  rst            in   1   reset; one clock; reset is asynchronous and active-high
//  flush          in   1   discard all entries (branch mispredict / exception / ertn)
//  in_valid       in   1   IF1 packet valid
//  in_ready       out  1   queue can take a full packet this cycle
//  in_pc          in   32  packet PC; bits [2:0] ignored for entry PCs
//  in_inst0       in   32  instruction at {in_pc[31:3],3'b000}
//  in_inst1       in   32  instruction at {in_pc[31:3],3'b100}
//  in_mask        in   2   per-slot valid; bit0 = inst0, bit1 = inst1
//  in_excp        in   7   exception code, copied into every entry of the packet
//  in_excp_flag   in   2   exception flag, copied into every entry of the packet
//  out_valid      out  2   bit0: entry at head valid; bit1: head+1 valid (only if bit0 valid)
//  out_pc0/1      out  32  PCs of head / head+1
//  out_inst0/1    out  32  instructions of head / head+1
//  out_excp0/1    out  7   exception code per output entry
//  out_flag0/1    out  2   exception flag per output entry
//  pop_num        in   2   entries consumed this cycle: 0, 1 or 2
// BEHAVIOUR
//  - Reset: wptr=rptr=0, count=0; in_ready=1, out_valid=2'b00. Array contents are not reset.
//  - Entry = {pc[31:0], inst[31:0], excp[6:0], flag[1:0]} = 73 bits.
//  - in_ready = (count <= DEPTH-2), from registered count only; no dependency on pop_num.
//  - Push occurs when in_valid & in_ready & ~flush. Number written n = popcount(in_mask).
//  - Push writes compacted entries:
//    - mask 11: inst0 goes to wptr, inst1 goes to wptr+1.
//    - mask 01: inst0 goes to wptr.
//    - mask 10: inst1 goes to wptr (odd-PC branch target).
//    - mask 00: no write.
//    - wptr += n, modulo DEPTH.
//  - Pop: rptr += pop_num modulo DEPTH; count -= pop_num in the same cycle as any push.
//  - Pop legality: pop_num greater than popcount(out_valid) is illegal; assert in simulation.
//  - Outputs are combinational reads at rptr and rptr+1 (wrapped).
//    - out_valid[0] = (count >= 1); out_valid[1] = (count >= 2).
//    - A pushed entry is visible at the output one cycle after the push. No same-cycle bypass.
//  - Simultaneous push and pop: count_next = count + n - pop_num.
//  - Pointers wrap modulo DEPTH. The full condition is count == DEPTH, never derived from pointers.
//  - Flush has priority over push and pop: wptr=rptr=0, count=0 next cycle.
//    - out_valid=0 in the cycle after flush; in_ready=1 in the cycle after flush.
//  - Async rst mid-operation: all state clears immediately; entries in flight are lost.
// STRUCTURE
//  - define.vh holds the entry field widths (IFQ_EXCP_W=7, IFQ_FLAG_W=2), the entry width, and `INST_NOP.
//  - Sub-module: ifq_ram_2w2r, a DEPTH x 73 register array with 2 write ports and 2 async read ports.
//    - Both write ports are used in the same cycle; indices never collide.
//  - Top level keeps pointers, count, compaction mux and flush logic.
// TESTING
//  1. Reset, then push mask 11, pc=0x1c000000.
//     -> Next cycle: out_valid=11, out_pc0=0x1c000000, out_pc1=0x1c000004, count=2.
//  2. Push mask 10, pc=0x1c000024.
//     -> Single entry at head: out_pc0=0x1c000024, out_inst0=in_inst1, out_valid=01.
//  3. Fill to 7 entries.
//     -> in_ready=0.
//     Then pop_num=2 with in_valid held.
//     -> Next cycle in_ready=1; order preserved across the rptr wrap 7 -> 1.
//  4. count=6; push mask 11 and pop_num=1 in the same cycle.
//     -> count=7; wptr and rptr both wrap correctly.
//  5. count=5; flush together with in_valid and pop_num=2.
//     -> Next cycle count=0, out_valid=00, in_ready=1; nothing written.
//  6. Push with in_excp=0x0c, flag=2'b01, mask 11.
//     -> Both entries carry excp 0x0c / flag 01.
//     Assert async rst mid-stream -> out_valid=00 immediately.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package inst_fetch_queue_pkg;

   localparam int IFQ_DEPTH   = 8;
   localparam int IFQ_PTR_W   = 3;
   localparam int IFQ_PC_W    = 32;
   localparam int IFQ_INST_W  = 32;
   localparam int IFQ_EXCP_W  = 7;
   localparam int IFQ_FLAG_W  = 2;
   localparam int IFQ_ENTRY_W = IFQ_PC_W + IFQ_INST_W + IFQ_EXCP_W + IFQ_FLAG_W;

   // andi r0,r0,0 -- presented on instruction outputs whose slot holds no entry
   localparam logic [IFQ_INST_W-1:0] INST_NOP = 32'h0340_0000;

   typedef struct packed {
      logic [IFQ_PC_W-1:0]   pc;
      logic [IFQ_INST_W-1:0] inst;
      logic [IFQ_EXCP_W-1:0] excp;
      logic [IFQ_FLAG_W-1:0] flag;
   } ifq_entry_t;

   // Number of valid slots in a fetch packet mask
   function automatic logic [1:0] mask_popcount(input logic [1:0] mask);
      return {1'b0, mask[0]} + {1'b0, mask[1]};
   endfunction

endpackage

// File: rtl/inst_fetch_queue_ram_2w2r.sv
// Entry storage: DEPTH x entry register array, two write ports, two async read ports.
// The queue never drives both write ports at the same index in one cycle.
module ifq_ram_2w2r
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH,
   parameter int PTR_W = IFQ_PTR_W
) (
   input  logic             clk,
   input  logic             we0,
   input  logic [PTR_W-1:0] waddr0,
   input  ifq_entry_t       wdata0,
   input  logic             we1,
   input  logic [PTR_W-1:0] waddr1,
   input  ifq_entry_t       wdata1,
   input  logic [PTR_W-1:0] raddr0,
   output ifq_entry_t       rdata0,
   input  logic [PTR_W-1:0] raddr1,
   output ifq_entry_t       rdata1
);

   ifq_entry_t mem_q [DEPTH];

   // Write both ports on the clock edge; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we0) mem_q[waddr0] <= wdata0;
      if (we1) mem_q[waddr1] <= wdata1;
   end

   // Combinational reads so the decoder sees the head entries in the same cycle
   always_comb begin
      rdata0 = mem_q[raddr0];
      rdata1 = mem_q[raddr1];
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: compacts IF1 packets into a circular buffer and
// presents the two oldest entries to the dual-issue decoder.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH,
   parameter int PTR_W = IFQ_PTR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IFQ_PC_W-1:0]   in_pc,
   input  logic [IFQ_INST_W-1:0] in_inst0,
   input  logic [IFQ_INST_W-1:0] in_inst1,
   input  logic [1:0]            in_mask,
   input  logic [IFQ_EXCP_W-1:0] in_excp,
   input  logic [IFQ_FLAG_W-1:0] in_excp_flag,
   output logic [1:0]            out_valid,
   output logic [IFQ_PC_W-1:0]   out_pc0,
   output logic [IFQ_PC_W-1:0]   out_pc1,
   output logic [IFQ_INST_W-1:0] out_inst0,
   output logic [IFQ_INST_W-1:0] out_inst1,
   output logic [IFQ_EXCP_W-1:0] out_excp0,
   output logic [IFQ_EXCP_W-1:0] out_excp1,
   output logic [IFQ_FLAG_W-1:0] out_flag0,
   output logic [IFQ_FLAG_W-1:0] out_flag1,
   input  logic [1:0]            pop_num
);

   localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W:0]   count_q, count_d;

   logic             push;
   logic [1:0]       push_num;
   logic [1:0]       avail_num;
   logic             we0, we1;
   logic [PTR_W-1:0] waddr1, raddr1;
   ifq_entry_t       entry_lo, entry_hi, wdata0, wdata1, rdata0, rdata1;
   logic             pc_lsb_unused;

   // Build both slot entries and steer them so the valid ones land contiguously at wptr
   always_comb begin
      entry_lo      = '{pc: {in_pc[31:3], 3'b000}, inst: in_inst0, excp: in_excp, flag: in_excp_flag};
      entry_hi      = '{pc: {in_pc[31:3], 3'b100}, inst: in_inst1, excp: in_excp, flag: in_excp_flag};
      pc_lsb_unused = ^in_pc[2:0];
      in_ready      = (count_q <= READY_MAX);
      push          = in_valid & in_ready & ~flush;
      push_num      = push ? mask_popcount(in_mask) : 2'd0;
      we0           = push & (|in_mask);
      we1           = push & (&in_mask);
      wdata0        = in_mask[0] ? entry_lo : entry_hi;
      wdata1        = entry_hi;
      waddr1        = wptr_q + 1'b1;
   end

   // Pointer and occupancy update; flush overrides any push or pop in the same cycle
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         wptr_d  = wptr_q + PTR_W'(push_num);
         rptr_d  = rptr_q + PTR_W'(pop_num);
         count_d = count_q + (PTR_W+1)'(push_num) - (PTR_W+1)'(pop_num);
      end
   end

   // State registers; reset drops every entry immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   ifq_ram_2w2r #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_ram (
      .clk    (clk),
      .we0    (we0),
      .waddr0 (wptr_q),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .raddr0 (rptr_q),
      .rdata0 (rdata0),
      .raddr1 (raddr1),
      .rdata1 (rdata1)
   );

   // Head and head+1 presented straight from the array; validity comes from the count alone
   always_comb begin
      raddr1       = rptr_q + 1'b1;
      out_valid[0] = |count_q;
      out_valid[1] = |count_q[PTR_W:1];
      avail_num    = out_valid[1] ? 2'd2 : (out_valid[0] ? 2'd1 : 2'd0);
      out_pc0      = rdata0.pc;
      out_pc1      = rdata1.pc;
      out_inst0    = out_valid[0] ? rdata0.inst : INST_NOP;
      out_inst1    = out_valid[1] ? rdata1.inst : INST_NOP;
      out_excp0    = rdata0.excp;
      out_excp1    = rdata1.excp;
      out_flag0    = rdata0.flag;
      out_flag1    = rdata1.flag;
   end

   pop_legal_a : assert property (@(posedge clk) disable iff (rst) pop_num <= avail_num);

endmodule
